// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE MAC sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pe_pkg;

    localparam int WIDTH_DEF      = 8;
    localparam int DEPTH_DEF      = 3;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int PSUM_WIDTH_DEF = 16;

    // All-ones address is reserved by the memories for frame readback.
    localparam logic [ADDR_WIDTH_DEF-1:0] FRAME_READBACK_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ACC,
        OUT
    } state_e;

endpackage

// File: rtl/pe_mac_sequencer_if.sv
// Bundles the job, filter/spike memory and result channels of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel; master = sequencer, slave = environment.
interface pe_mac_sequencer_if #(
    parameter int WIDTH      = pe_pkg::WIDTH_DEF,
    parameter int ADDR_WIDTH = pe_pkg::ADDR_WIDTH_DEF,
    parameter int PSUM_WIDTH = pe_pkg::PSUM_WIDTH_DEF
);
    logic                  start_valid;
    logic                  start_ready;
    logic [PSUM_WIDTH-1:0] start_psum;

    logic                  f_addr_valid;
    logic                  f_addr_ready;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_rdata_valid;
    logic                  f_rdata_ready;
    logic [WIDTH-1:0]      f_rdata;

    logic                  s_addr_valid;
    logic                  s_addr_ready;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic                  s_rdata_valid;
    logic                  s_rdata_ready;
    logic [WIDTH-1:0]      s_rdata;

    logic                  psum_valid;
    logic                  psum_ready;
    logic [PSUM_WIDTH-1:0] psum;
    logic                  ovf;

    modport master (
        input  start_valid, start_psum,
        output start_ready,
        output f_addr_valid, f_addr, f_rdata_ready,
        input  f_addr_ready, f_rdata_valid, f_rdata,
        output s_addr_valid, s_addr, s_rdata_ready,
        input  s_addr_ready, s_rdata_valid, s_rdata,
        output psum_valid, psum, ovf,
        input  psum_ready
    );

    modport slave (
        output start_valid, start_psum,
        input  start_ready,
        input  f_addr_valid, f_addr, f_rdata_ready,
        output f_addr_ready, f_rdata_valid, f_rdata,
        input  s_addr_valid, s_addr, s_rdata_ready,
        output s_addr_ready, s_rdata_valid, s_rdata,
        input  psum_valid, psum, ovf,
        output psum_ready
    );

endinterface

// File: rtl/pe_rd_port.sv
// One memory read port: issues a single address per element and captures the returned word.
// Latency: address valid while enabled until accepted; word registered on the data handshake.
// Backpressure: valids/readies derive only from enables and registered done flags.
module pe_rd_port #(
    parameter int WIDTH = pe_pkg::WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_en,
    input  logic             cap_en,
    input  logic             clr,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic             addr_done,
    input  logic             rdata_valid,
    input  logic [WIDTH-1:0] rdata,
    output logic             rdata_ready,
    output logic             data_done,
    output logic [WIDTH-1:0] word
);
    logic             addr_done_q, addr_done_d;
    logic             data_done_q, data_done_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             addr_xfer, data_xfer;

    assign addr_valid  = req_en & ~addr_done_q;
    assign rdata_ready = cap_en & ~data_done_q;
    assign addr_xfer   = addr_valid & addr_ready;
    assign data_xfer   = rdata_valid & rdata_ready;
    // Done includes the handshake of this cycle so the FSM can advance on the same edge.
    assign addr_done   = addr_done_q | addr_xfer;
    assign data_done   = data_done_q | data_xfer;
    assign word        = word_q;

    // Track per-element address/data progress; the word survives clr for use in ACC.
    always_comb begin
        addr_done_d = addr_done_q;
        data_done_d = data_done_q;
        word_d      = word_q;
        if (clr) begin
            addr_done_d = 1'b0;
            data_done_d = 1'b0;
        end else begin
            if (addr_xfer) addr_done_d = 1'b1;
            if (data_xfer) begin
                data_done_d = 1'b1;
                word_d      = rdata;
            end
        end
    end

    // Port state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_done_q <= 1'b0;
            data_done_q <= 1'b0;
            word_q      <= '0;
        end else begin
            addr_done_q <= addr_done_d;
            data_done_q <= data_done_d;
            word_q      <= word_d;
        end
    end

endmodule

// File: rtl/pe_mac_sequencer.sv
// Walks addresses 0..DEPTH-1 on filter and spike memories and MACs the pairs onto a partial sum.
// Latency: 3 cycles per element with zero-wait memories; result valid 3*DEPTH edges after start.
// Backpressure: stalls in any phase on missing handshakes; holds result until psum_ready.
module pe_mac_sequencer
    import pe_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    pe_mac_sequencer_if.master bus
);
    // The all-ones address is reserved, so the walk must stay strictly below it.
    if (DEPTH < 1 || longint'(DEPTH) >= (longint'(1) << ADDR_WIDTH) - 1) begin : g_depth_check
        $error("pe_mac_sequencer: DEPTH must be in 1 .. 2**ADDR_WIDTH-2");
    end

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [PSUM_WIDTH-1:0] acc_q, acc_d;
    logic                  ovf_q, ovf_d;

    logic                  f_addr_done, s_addr_done, f_data_done, s_data_done;
    logic [WIDTH-1:0]      f_word, s_word;
    logic [2*WIDTH-1:0]    prod;
    logic [PSUM_WIDTH:0]   sum;

    pe_rd_port #(.WIDTH(WIDTH)) u_f_port (
        .clk        (clk),
        .rst        (rst),
        .req_en     (state_q == REQ),
        .cap_en     (state_q == WAIT),
        .clr        (state_q == ACC),
        .addr_valid (bus.f_addr_valid),
        .addr_ready (bus.f_addr_ready),
        .addr_done  (f_addr_done),
        .rdata_valid(bus.f_rdata_valid),
        .rdata      (bus.f_rdata),
        .rdata_ready(bus.f_rdata_ready),
        .data_done  (f_data_done),
        .word       (f_word)
    );

    pe_rd_port #(.WIDTH(WIDTH)) u_s_port (
        .clk        (clk),
        .rst        (rst),
        .req_en     (state_q == REQ),
        .cap_en     (state_q == WAIT),
        .clr        (state_q == ACC),
        .addr_valid (bus.s_addr_valid),
        .addr_ready (bus.s_addr_ready),
        .addr_done  (s_addr_done),
        .rdata_valid(bus.s_rdata_valid),
        .rdata      (bus.s_rdata),
        .rdata_ready(bus.s_rdata_ready),
        .data_done  (s_data_done),
        .word       (s_word)
    );

    assign bus.start_ready = (state_q == IDLE);
    assign bus.psum_valid  = (state_q == OUT);
    assign bus.psum        = acc_q;
    assign bus.ovf         = ovf_q;
    assign bus.f_addr      = idx_q;
    assign bus.s_addr      = idx_q;

    // Next-state and datapath: one element per REQ/WAIT/ACC pass, wrap-around accumulate.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        prod    = (2*WIDTH)'(f_word) * (2*WIDTH)'(s_word);
        sum     = {1'b0, acc_q} + (PSUM_WIDTH+1)'(prod);
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    acc_d   = bus.start_psum;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (f_addr_done && s_addr_done) state_d = WAIT;
            end
            WAIT: begin
                if (f_data_done && s_data_done) state_d = ACC;
            end
            ACC: begin
                acc_d = sum[PSUM_WIDTH-1:0];
                ovf_d = ovf_q | sum[PSUM_WIDTH];
                if (idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = OUT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = REQ;
                end
            end
            OUT: begin
                if (bus.psum_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
